// File: rtl/title_screen_if.sv
// VGA raster bundle: timing counters, sync/blank strobes and 12-bit rgb.
interface vga_if;
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        hsync;
    logic        vblnk;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
    modport out (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
endinterface

// File: rtl/title_screen.sv
// Title overlay: draws a blinking, fading "START GAME" box over a 2-stage VGA pipeline.
// Optional TITLE_SCREEN_BORDER_EN paints fixed colours on the active-area edge pixels.
module title_screen #(
    parameter int          TEXT_X     = 160,
    parameter int          TEXT_Y     = 256,
    parameter int          SCALE_LOG2 = 2,
    parameter logic [11:0] BG_RGB     = 12'hFF0,
    parameter logic [11:0] FG_RGB     = 12'h000,
    parameter logic [11:0] FIELD_RGB  = 12'h0F0,
`ifdef TITLE_SCREEN_BORDER_EN
    parameter int          HOR_PIXELS = 800,
    parameter int          VER_PIXELS = 600,
`endif
    parameter int          BLINK_HALF = 30
) (
    input  logic clk,
    input  logic rst_n,
    vga_if.in    vga_in,
    vga_if.out   vga_out,
    input  logic start_req,
    output logic start_done
);

    localparam int          BOX_W = 80 << SCALE_LOG2;
    localparam int          BOX_H = 8 << SCALE_LOG2;
    localparam logic [11:0] BOX_X0 = 12'(TEXT_X);
    localparam logic [11:0] BOX_X1 = 12'(TEXT_X + BOX_W);
    localparam logic [11:0] BOX_Y0 = 12'(TEXT_Y);
    localparam logic [11:0] BOX_Y1 = 12'(TEXT_Y + BOX_H);
    localparam int          BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    // 8x8 glyphs, top row in the MSB byte, leftmost pixel in the MSB of each row
    localparam logic [63:0] GL_S = 64'h3C66603C06663C00;
    localparam logic [63:0] GL_T = 64'h7E18181818181800;
    localparam logic [63:0] GL_A = 64'h183C66667E666600;
    localparam logic [63:0] GL_R = 64'h7C66667C786C6600;
    localparam logic [63:0] GL_G = 64'h3C66606E66663C00;
    localparam logic [63:0] GL_M = 64'h63777F6B63636300;
    localparam logic [63:0] GL_E = 64'h7E60607C60607E00;

    typedef enum logic [1:0] {FADE_IN, SHOW, FADE_OUT, DONE} state_t;

    function automatic logic [7:0] glyph_row(input logic [3:0] ch, input logic [2:0] row);
        logic [63:0] g;
        case (ch)
            4'd0:       g = GL_S;
            4'd1, 4'd4: g = GL_T;
            4'd2, 4'd7: g = GL_A;
            4'd3:       g = GL_R;
            4'd6:       g = GL_G;
            4'd8:       g = GL_M;
            4'd9:       g = GL_E;
            default:    g = 64'h0;
        endcase
        return g[{3'd7 - row, 3'b000} +: 8];
    endfunction

    function automatic logic [11:0] fade(input logic [11:0] c, input logic [3:0] lv);
        logic [7:0]  p;
        logic [11:0] o;
        o = '0;
        for (int k = 0; k < 3; k++) begin
            p = {4'd0, c[4*k +: 4]} * ({4'd0, lv} + 8'd1);
            o[4*k +: 4] = 4'(p >> 4);
        end
        return o;
    endfunction

    state_t        r_state;
    logic [3:0]    r_level;
    logic [BW-1:0] r_blink;
    logic          r_vis;
    logic          r_vblnk_prev;
    logic          r_done;
    logic          w_tick;
    logic          w_unused;

    assign w_tick   = vga_in.vblnk & ~r_vblnk_prev;
    assign w_unused = ^vga_in.rgb;

    // start_req outranks a coincident tick, so level holds on that cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= FADE_IN;
            r_level      <= 4'd0;
            r_blink      <= '0;
            r_vis        <= 1'b0;
            r_vblnk_prev <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_vblnk_prev <= vga_in.vblnk;
            case (r_state)
                FADE_IN: begin
                    if (start_req) begin
                        r_state <= FADE_OUT;
                        r_vis   <= 1'b1;
                    end else if (w_tick) begin
                        r_level <= r_level + 4'd1;
                        if (r_level == 4'd14) begin
                            r_state <= SHOW;
                            r_vis   <= 1'b1;
                            r_blink <= '0;
                        end
                    end
                end
                SHOW: begin
                    if (start_req) begin
                        r_state <= FADE_OUT;
                        r_vis   <= 1'b1;
                    end else if (w_tick) begin
                        if (r_blink == BLINK_LAST) begin
                            r_blink <= '0;
                            r_vis   <= ~r_vis;
                        end else begin
                            r_blink <= r_blink + 1'b1;
                        end
                    end
                end
                FADE_OUT: begin
                    if (w_tick) begin
                        if (r_level == 4'd0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_level <= r_level - 4'd1;
                        end
                    end
                end
                DONE: ;
                default: r_state <= FADE_IN;
            endcase
        end
    end

    assign start_done = r_done;

    // Stage 1: box-relative geometry plus a snapshot of the sequence state
    logic [11:0] w_hx, w_vy, w_dx, w_dy;
    logic [6:0]  w_col;
    logic [2:0]  w_row;
    logic        w_inbox;

    assign w_hx    = {1'b0, vga_in.hcount};
    assign w_vy    = {1'b0, vga_in.vcount};
    assign w_dx    = w_hx - BOX_X0;
    assign w_dy    = w_vy - BOX_Y0;
    assign w_col   = 7'(w_dx >> SCALE_LOG2);
    assign w_row   = 3'(w_dy >> SCALE_LOG2);
    assign w_inbox = (w_hx >= BOX_X0) && (w_hx < BOX_X1) && (w_vy >= BOX_Y0) && (w_vy < BOX_Y1);

    logic [10:0] r_s1_vcount, r_s1_hcount;
    logic        r_s1_vsync, r_s1_hsync, r_s1_vblnk, r_s1_hblnk;
    logic [3:0]  r_s1_char;
    logic [2:0]  r_s1_grow, r_s1_gcol;
    logic        r_s1_inbox, r_s1_active, r_s1_vis, r_s1_done;
    logic [3:0]  r_s1_level;
`ifdef TITLE_SCREEN_BORDER_EN
    logic [3:0]  r_s1_edge;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vcount <= '0;
            r_s1_hcount <= '0;
            r_s1_vsync  <= 1'b0;
            r_s1_hsync  <= 1'b0;
            r_s1_vblnk  <= 1'b0;
            r_s1_hblnk  <= 1'b0;
            r_s1_char   <= '0;
            r_s1_grow   <= '0;
            r_s1_gcol   <= '0;
            r_s1_inbox  <= 1'b0;
            r_s1_active <= 1'b0;
            r_s1_vis    <= 1'b0;
            r_s1_done   <= 1'b0;
            r_s1_level  <= '0;
`ifdef TITLE_SCREEN_BORDER_EN
            r_s1_edge   <= '0;
`endif
        end else begin
            r_s1_vcount <= vga_in.vcount;
            r_s1_hcount <= vga_in.hcount;
            r_s1_vsync  <= vga_in.vsync;
            r_s1_hsync  <= vga_in.hsync;
            r_s1_vblnk  <= vga_in.vblnk;
            r_s1_hblnk  <= vga_in.hblnk;
            r_s1_char   <= w_col[6:3];
            r_s1_gcol   <= w_col[2:0];
            r_s1_grow   <= w_row;
            r_s1_inbox  <= w_inbox;
            r_s1_active <= ~vga_in.vblnk & ~vga_in.hblnk;
            r_s1_vis    <= r_vis;
            r_s1_done   <= r_done;
            r_s1_level  <= r_level;
`ifdef TITLE_SCREEN_BORDER_EN
            r_s1_edge   <= {vga_in.hcount == 11'(HOR_PIXELS - 1), vga_in.hcount == 11'd0,
                            vga_in.vcount == 11'(VER_PIXELS - 1), vga_in.vcount == 11'd0};
`endif
        end
    end

    // Stage 2: glyph lookup, colour select and fade
    logic [7:0]  w_bits;
    logic        w_set;
    logic [11:0] w_base, w_rgb;

    assign w_bits = glyph_row(r_s1_char, r_s1_grow);
    assign w_set  = w_bits[3'd7 - r_s1_gcol];

    always_comb begin
        w_base = r_s1_inbox ? ((w_set && r_s1_vis) ? FG_RGB : BG_RGB) : FIELD_RGB;
        w_rgb  = 12'h000;
        if (r_s1_active && !r_s1_done)
            w_rgb = fade(w_base, r_s1_level);
`ifdef TITLE_SCREEN_BORDER_EN
        if (r_s1_active) begin
            if (r_s1_edge[0])      w_rgb = 12'hFF0;
            else if (r_s1_edge[1]) w_rgb = 12'hF00;
            else if (r_s1_edge[2]) w_rgb = 12'h0F0;
            else if (r_s1_edge[3]) w_rgb = 12'h00F;
        end
`endif
    end

    logic [10:0] r_s2_vcount, r_s2_hcount;
    logic        r_s2_vsync, r_s2_hsync, r_s2_vblnk, r_s2_hblnk;
    logic [11:0] r_s2_rgb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vcount <= '0;
            r_s2_hcount <= '0;
            r_s2_vsync  <= 1'b0;
            r_s2_hsync  <= 1'b0;
            r_s2_vblnk  <= 1'b0;
            r_s2_hblnk  <= 1'b0;
            r_s2_rgb    <= '0;
        end else begin
            r_s2_vcount <= r_s1_vcount;
            r_s2_hcount <= r_s1_hcount;
            r_s2_vsync  <= r_s1_vsync;
            r_s2_hsync  <= r_s1_hsync;
            r_s2_vblnk  <= r_s1_vblnk;
            r_s2_hblnk  <= r_s1_hblnk;
            r_s2_rgb    <= w_rgb;
        end
    end

    assign vga_out.vcount = r_s2_vcount;
    assign vga_out.hcount = r_s2_hcount;
    assign vga_out.vsync  = r_s2_vsync;
    assign vga_out.hsync  = r_s2_hsync;
    assign vga_out.vblnk  = r_s2_vblnk;
    assign vga_out.hblnk  = r_s2_hblnk;
    assign vga_out.rgb    = r_s2_rgb;

endmodule

// File: tb/tb_title_screen.sv
// Randomised bench for title_screen against a frame-event level reference model.
module tb_title_screen;
    localparam int BH = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_req = 1'b0;
    logic start_done;

    vga_if vin();
    vga_if vout();

    title_screen #(.BLINK_HALF(BH)) dut (
        .clk(clk), .rst_n(rst_n), .vga_in(vin), .vga_out(vout),
        .start_req(start_req), .start_done(start_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: phase 0 fading in, 1 showing, 2 fading out, 3 finished
    int m_phase, m_level, m_vis, m_blink;

    typedef struct {
        logic [11:0] rgb;
        logic [10:0] h, v;
        logic        hs, vs, hb;
    } exp_t;

    function automatic logic [63:0] glyph(input int idx);
        case (idx)
            0: return 64'h3C66603C06663C00;
            1, 4: return 64'h7E18181818181800;
            2, 7: return 64'h183C66667E666600;
            3: return 64'h7C66667C786C6600;
            6: return 64'h3C66606E66663C00;
            8: return 64'h63777F6B63636300;
            9: return 64'h7E60607C60607E00;
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic [11:0] exp_rgb(input int h, input int v, input bit hb, input bit vb);
        logic [11:0] base, r;
        logic [63:0] g;
        int ch, col, row;
        if (hb || vb) return 12'h000;
`ifdef TITLE_SCREEN_BORDER_EN
        if (v == 0)   return 12'hFF0;
        if (v == 599) return 12'hF00;
        if (h == 0)   return 12'h0F0;
        if (h == 799) return 12'h00F;
`endif
        if (m_phase == 3) return 12'h000;
        base = 12'h0F0;
        if (h >= 160 && h < 160 + 320 && v >= 256 && v < 256 + 32) begin
            ch  = (h - 160) / 32;
            col = ((h - 160) / 4) % 8;
            row = (v - 256) / 4;
            g   = glyph(ch);
            base = (m_vis != 0 && g[63 - row*8 - col]) ? 12'h000 : 12'hFF0;
        end
        r = '0;
        for (int k = 0; k < 3; k++)
            r[4*k +: 4] = 4'((int'(base[4*k +: 4]) * (m_level + 1)) / 16);
        return r;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_level = 0; m_vis = 0; m_blink = 0;
    endtask

    task automatic model_event(input bit start, input bit tick);
        if (start && m_phase < 2) begin
            m_phase = 2;
            m_vis   = 1;
        end else if (tick) begin
            if (m_phase == 0) begin
                m_level++;
                if (m_level == 15) begin m_phase = 1; m_vis = 1; m_blink = 0; end
            end else if (m_phase == 1) begin
                m_blink++;
                if (m_blink == BH) begin m_blink = 0; m_vis = 1 - m_vis; end
            end else if (m_phase == 2) begin
                if (m_level == 0) m_phase = 3;
                else m_level--;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_tick(input bit with_start);
        vin.vblnk = 1'b1; vin.hblnk = 1'b1; start_req = with_start;
        step();
        start_req = 1'b0; vin.vblnk = 1'b0; vin.hblnk = 1'b0;
        model_event(with_start, 1'b1);
        step();
    endtask

    task automatic pulse_start();
        start_req = 1'b1;
        step();
        start_req = 1'b0;
        model_event(1'b1, 1'b0);
    endtask

    task automatic check_pixel(input int h, input int v, input string name);
        logic [11:0] e;
        vin.hcount = 11'(h); vin.vcount = 11'(v);
        vin.hblnk = 1'b0; vin.vblnk = 1'b0;
        step(); step();
        e = exp_rgb(h, v, 1'b0, 1'b0);
        n_tests++;
        if (vout.rgb !== e) begin
            n_fail++;
            $display("FAIL %s (%0d,%0d): rgb=%h expected %h", name, h, v, vout.rgb, e);
        end
    endtask

    task automatic check_done(input string name);
        logic e;
        e = (m_phase == 3);
        n_tests++;
        if (start_done !== e) begin
            n_fail++;
            $display("FAIL %s: start_done=%b expected %b", name, start_done, e);
        end
    endtask

    task automatic check_out_zero(input string name);
        n_tests++;
        if ({vout.vcount, vout.hcount, vout.vsync, vout.hsync, vout.vblnk, vout.hblnk,
             vout.rgb, start_done} !== '0) begin
            n_fail++;
            $display("FAIL %s: outputs v=%0d h=%0d rgb=%h done=%b expected all zero",
                     name, vout.vcount, vout.hcount, vout.rgb, start_done);
        end
    endtask

    task automatic test_reset();
        vin.hcount = 11'd300; vin.vcount = 11'd270; vin.hsync = 1'b1; vin.vsync = 1'b1;
        vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = 12'hABC;
        rst_n = 1'b0;
        repeat (3) step();
        check_out_zero("reset_outputs");
        vin.hsync = 1'b0; vin.vsync = 1'b0;
        rst_n = 1'b1;
        model_reset();
        check_done("reset_done");
    endtask

    task automatic test_fade_in();
        check_pixel(0, 100, "first_frame");
        check_pixel(0, 0, "corner_l0");
        for (int i = 1; i <= 15; i++) begin
            apply_tick(1'b0);
            check_pixel(0, 100, $sformatf("fade_in_l%0d", m_level));
            if (i == 8) check_pixel(168, 256, "fade_in_text");
        end
        check_pixel(168, 256, "show_entry_visible");
        check_pixel(0, 0, "corner_l15");
        check_done("show_not_done");
    endtask

    task automatic test_text_stream();
        exp_t q[$];
        exp_t e, o;
        int h, v;
        check_pixel(160, 256, "S_row0_bit0");
        check_pixel(168, 256, "S_first_set");
        check_pixel(799, 599, "far_corner");
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) != 0) begin
                h = $urandom_range(150, 490); v = $urandom_range(250, 295);
            end else begin
                h = $urandom_range(0, 799); v = $urandom_range(0, 599);
            end
            vin.hcount = 11'(h); vin.vcount = 11'(v);
            vin.hsync = 1'($urandom_range(0, 1)); vin.vsync = 1'($urandom_range(0, 1));
            vin.hblnk = ($urandom_range(0, 7) == 0);
            e.h = 11'(h); e.v = 11'(v); e.hs = vin.hsync; e.vs = vin.vsync; e.hb = vin.hblnk;
            e.rgb = exp_rgb(h, v, vin.hblnk, 1'b0);
            q.push_back(e);
            step();
            if (q.size() == 2) begin
                o = q.pop_front();
                n_tests++;
                if (vout.rgb !== o.rgb) begin
                    n_fail++;
                    $display("FAIL stream_rgb (%0d,%0d): rgb=%h expected %h", o.h, o.v, vout.rgb, o.rgb);
                end
                n_tests++;
                if ({vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk} !==
                    {o.h, o.v, o.hs, o.vs, o.hb, 1'b0}) begin
                    n_fail++;
                    $display("FAIL stream_timing: h=%0d v=%0d expected h=%0d v=%0d",
                             vout.hcount, vout.vcount, o.h, o.v);
                end
            end
        end
        vin.hsync = 1'b0; vin.vsync = 1'b0;
    endtask

    task automatic test_blink();
        for (int i = 0; i < 6; i++) begin
            apply_tick(1'b0);
            check_pixel(168, 256, $sformatf("blink_t%0d", i + 1));
        end
    endtask

    task automatic test_start_show();
        pulse_start();
        check_pixel(0, 100, "fade_out_l15");
        check_pixel(168, 256, "fade_out_visible");
        for (int i = 0; i < 15; i++) begin
            apply_tick(1'b0);
            check_pixel(0, 100, $sformatf("fade_out_l%0d", m_level));
        end
        check_done("level0_not_done");
        apply_tick(1'b0);
        check_done("done_flag");
        check_pixel(0, 100, "done_field");
        check_pixel(160, 256, "done_box");
        check_pixel(0, 0, "done_corner");
        pulse_start();
        apply_tick(1'b0);
        check_done("done_ignores_start");
    endtask

    task automatic test_reset_in_done();
        rst_n = 1'b0;
        #2;
        check_out_zero("async_reset_done");
        repeat (2) step();
        rst_n = 1'b1;
        model_reset();
        check_pixel(0, 100, "restart_l0");
        check_done("restart_done");
    endtask

    task automatic test_start_tick();
        for (int i = 0; i < 7; i++) apply_tick(1'b0);
        check_pixel(0, 100, "fade_in_l7");
        apply_tick(1'b1);
        check_pixel(0, 100, "coincide_keep_l7");
        check_pixel(168, 256, "coincide_visible");
        apply_tick(1'b0);
        check_pixel(0, 100, "fade_out_l6");
        pulse_start();
        apply_tick(1'b0);
        check_pixel(0, 100, "fade_out_ignores_start");
        check_pixel(0, 0, "corner_fade_out");
    endtask

    initial begin
        vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.vsync = 1'b0;
        vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = '0;
        model_reset();
        test_reset();
        test_fade_in();
        test_text_stream();
        test_blink();
        test_start_show();
        test_reset_in_done();
        test_start_tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/title_screen.md
TITLE_SCREEN -- requirements
Module: title_screen

Interface
REQ-001 The module SHALL have the parameter TEXT_X, default 160, meaning the left pixel column of the text box.
REQ-002 The module SHALL have the parameter TEXT_Y, default 256, meaning the top pixel row of the text box.
REQ-003 The module SHALL have the parameter SCALE_LOG2, default 2, range 0..3, meaning the glyph magnification: each 8x8 glyph is drawn 2^SCALE_LOG2 times larger.
REQ-004 The module SHALL have the parameters BG_RGB (12'hFF0), FG_RGB (12'h000) and FIELD_RGB (12'h0F0), meaning the text-box background, glyph and screen-field colours.
REQ-005 The module SHALL have the parameter BLINK_HALF, default 30, range >=1, meaning the number of frames per blink phase.
REQ-006 The module SHALL have the port clk, input, 1 bit: pixel clock.
REQ-007 The module SHALL have the port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 The module SHALL have the port vga_in, vga_if.in: timing and rgb in.
REQ-009 The module SHALL have the port vga_out, vga_if.out: timing and rgb out.
REQ-010 The module SHALL have the port start_req, input, 1 bit: single-cycle, already-synchronised start request.
REQ-011 The module SHALL have the port start_done, output, 1 bit: the title sequence has finished.

Function
REQ-012 vcount, hcount, vsync, hsync, vblnk and hblnk SHALL all be forwarded with exactly 2-cycle latency, matching the rgb latency.
REQ-013 Pipeline stage 1 SHALL register the character index, glyph row/column and region flags; stage 2 SHALL register the final rgb.
REQ-014 The text SHALL be the fixed 10-character string "START GAME", read from an internal 8x8 glyph ROM holding the glyphs S, T, A, R, G, M, E and space.
REQ-015 The text box SHALL be [TEXT_X, TEXT_X+80*2^SCALE_LOG2) x [TEXT_Y, TEXT_Y+8*2^SCALE_LOG2).
REQ-016 Glyph column and row SHALL be computed by shifting the box-relative offset right by SCALE_LOG2; no divider is permitted.
REQ-017 During blanking (vblnk or hblnk high), rgb SHALL be 12'h000.
REQ-018 In the active area outside the box, rgb SHALL be FIELD_RGB.
REQ-019 Inside the box, rgb SHALL be FG_RGB on a set glyph bit while text is visible, and BG_RGB otherwise.
REQ-020 A frame tick SHALL be a rising edge of vga_in.vblnk, detected with a registered copy of vblnk.
REQ-021 The FSM SHALL have the states FADE_IN, SHOW, FADE_OUT and DONE, and a 4-bit level register.
REQ-022 In FADE_IN, level SHALL increment by 1 per tick; on the tick that makes level 15 the FSM SHALL go to SHOW.
REQ-023 In SHOW, a blink counter SHALL toggle text visibility every BLINK_HALF ticks; text SHALL be visible on entry to SHOW.
REQ-024 A start_req in FADE_IN or SHOW SHALL move the FSM to FADE_OUT on the next clock, keeping the current level.
REQ-025 In FADE_OUT, text SHALL be visible, and level SHALL decrement by 1 per tick; when level is 0 on a tick, the FSM SHALL go to DONE.
REQ-026 DONE SHALL be terminal until reset; in DONE, rgb SHALL be 12'h000 in the active area and start_done SHALL be 1.
REQ-027 Fade SHALL be applied per 4-bit channel as out = (c*(level+1))>>4, so level 15 gives c unchanged and level 0 gives 0; it SHALL apply to every active-area colour.
REQ-028 If start_req and a frame tick coincide, the start_req transition SHALL take priority, and level SHALL not change that cycle.
REQ-029 start_req in FADE_OUT or DONE SHALL be ignored.
REQ-030 State, level or blink changes SHALL affect only pixels entering stage 1 after the change; no mid-pixel glitching is permitted.

Reset
REQ-031 While rst_n is 0, all vga_out fields, start_done, level, blink counter, visibility and vblnk history SHALL be 0, asynchronously.
REQ-032 While rst_n is 0, the state SHALL be FADE_IN.
REQ-033 Reset asserted mid-fade or mid-DONE SHALL restart the sequence from FADE_IN with level 0.

Configuration
REQ-034 With TITLE_SCREEN_BORDER_EN defined, active-area edge pixels SHALL override all other colours, without fade:
- vcount 0: 12'hFF0
- vcount VER_PIXELS-1: 12'hF00
- hcount 0: 12'h0F0
- hcount HOR_PIXELS-1: 12'h00F
REQ-035 Without TITLE_SCREEN_BORDER_EN, edge pixels SHALL follow REQ-017 to REQ-019 and no edge-compare logic SHALL be present.

Verification
REQ-036 The bench SHALL cover: reset release, pixel (hcount 0, vcount 100), first frame -> rgb 12'h000 (level 0); after 15 ticks, rgb 12'h0F0 and state SHOW.
REQ-037 The bench SHALL cover: SHOW, defaults, pixel (160,256), glyph 'S' row 0 bit 0 clear -> 12'hFF0; first set-bit pixel -> 12'h000; input-to-output delay exactly 2 clocks.
REQ-038 The bench SHALL cover: SHOW, BLINK_HALF=2 -> text pixels alternate 12'h000 / 12'hFF0 every 2 frames.
REQ-039 The bench SHALL cover: start_req pulse in SHOW -> FADE_OUT; after 15 ticks level 0, next tick DONE, start_done=1, active rgb 12'h000.
REQ-040 The bench SHALL cover: start_req coincident with a tick at level 7 in FADE_IN -> FADE_OUT with level 7, then level 6 on the next tick.
REQ-041 The bench SHALL cover: rst_n pulsed low in DONE -> start_done=0, vga_out=0 immediately, sequence restarts; with TITLE_SCREEN_BORDER_EN, pixel (0,0) -> 12'hFF0 at every level.
